// File: rtl/snake_step_ctrl.sv
// Snake game-step scheduler: tick divider, button arbitration, wall check,
// serial self-collision scan and body-shift commit over a 16-entry segment array.
module snake_step_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [4:0] length,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_pos,
  output logic       rd_valid,
  output logic       step_done,
  output logic       ate,
  output logic       running,
  output logic       game_over
);

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    MAX_LEN_V = 5'(MAX_LEN);

  typedef enum logic [2:0] {ST_STOP, ST_WAIT, ST_SCAN, ST_COMMIT, ST_DEAD} state_t;
  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t        state_q;
  logic [CW-1:0] tickCnt_q;
  dir_t          heading_q;
  dir_t          pending_q;
  logic [7:0]    body_q [16];
  logic [4:0]    len_q;
  logic [7:0]    nextHead_q;
  logic          eat_q;
  logic [3:0]    scanIdx_q;
  logic          stepDone_q;
  logic          ate_q;
  logic          running_q;
  logic          gameOver_q;

  dir_t       btnDir_d;
  logic       btnHit_d;
  logic       btnLegal_d;
  logic [4:0] headX_d;
  logic [4:0] headY_d;
  logic [4:0] nextX_d;
  logic [4:0] nextY_d;
  logic       wall_d;
  logic       scanLast_d;
  logic       scanHit_d;

  always_comb begin
    btnHit_d = 1'b1;
    btnDir_d = DIR_RIGHT;
    if (btn[3])      btnDir_d = DIR_UP;
    else if (btn[2]) btnDir_d = DIR_DOWN;
    else if (btn[1]) btnDir_d = DIR_LEFT;
    else if (btn[0]) btnDir_d = DIR_RIGHT;
    else             btnHit_d = 1'b0;
    btnLegal_d = btnHit_d && (dir_t'(btnDir_d ^ 2'b01) != heading_q);
  end

  // A fifth bit on each coordinate flags a step off either edge of the grid.
  always_comb begin
    headX_d = {1'b0, body_q[0][7:4]};
    headY_d = {1'b0, body_q[0][3:0]};
    nextX_d = headX_d;
    nextY_d = headY_d;
    case (pending_q)
      DIR_UP:    nextY_d = headY_d - 5'd1;
      DIR_DOWN:  nextY_d = headY_d + 5'd1;
      DIR_LEFT:  nextX_d = headX_d - 5'd1;
      DIR_RIGHT: nextX_d = headX_d + 5'd1;
      default:   nextX_d = headX_d;
    endcase
    wall_d = nextX_d[4] | nextY_d[4];
  end

  always_comb begin
    scanLast_d = ({1'b0, scanIdx_q} == (len_q - 5'd1));
    scanHit_d  = (body_q[scanIdx_q] == nextHead_q) && !(scanLast_d && !eat_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      tickCnt_q  <= '0;
      heading_q  <= DIR_RIGHT;
      pending_q  <= DIR_RIGHT;
      for (int i = 0; i < 16; i++) body_q[i] <= 8'h00;
      body_q[0]  <= 8'h88;
      body_q[1]  <= 8'h78;
      body_q[2]  <= 8'h68;
      len_q      <= 5'd3;
      nextHead_q <= 8'h00;
      eat_q      <= 1'b0;
      scanIdx_q  <= 4'd0;
      stepDone_q <= 1'b0;
      ate_q      <= 1'b0;
      running_q  <= 1'b0;
      gameOver_q <= 1'b0;
    end else begin
      stepDone_q <= 1'b0;
      ate_q      <= 1'b0;
      if (ena) begin
        if (running_q && btnLegal_d) pending_q <= btnDir_d;
        case (state_q)
          ST_STOP, ST_DEAD: begin
            if (start) begin
              state_q    <= ST_WAIT;
              tickCnt_q  <= '0;
              heading_q  <= DIR_RIGHT;
              pending_q  <= DIR_RIGHT;
              for (int i = 0; i < 16; i++) body_q[i] <= 8'h00;
              body_q[0]  <= 8'h88;
              body_q[1]  <= 8'h78;
              body_q[2]  <= 8'h68;
              len_q      <= 5'd3;
              eat_q      <= 1'b0;
              scanIdx_q  <= 4'd0;
              running_q  <= 1'b1;
              gameOver_q <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (tickCnt_q == TICK_LAST) begin
              tickCnt_q <= '0;
              heading_q <= pending_q;
              if (wall_d) begin
                state_q    <= ST_DEAD;
                running_q  <= 1'b0;
                gameOver_q <= 1'b1;
              end else begin
                nextHead_q <= {nextX_d[3:0], nextY_d[3:0]};
                eat_q      <= ({nextX_d[3:0], nextY_d[3:0]} == {food_x, food_y});
                scanIdx_q  <= 4'd0;
                state_q    <= ST_SCAN;
              end
            end else begin
              tickCnt_q <= tickCnt_q + CW'(1);
            end
          end
          ST_SCAN: begin
            if (scanHit_d) begin
              state_q    <= ST_DEAD;
              running_q  <= 1'b0;
              gameOver_q <= 1'b1;
            end else if (scanLast_d) begin
              state_q <= ST_COMMIT;
            end else begin
              scanIdx_q <= scanIdx_q + 4'd1;
            end
          end
          ST_COMMIT: begin
            // Shifting the whole array carries the old tail into the new slot on growth.
            for (int i = 15; i > 0; i--) body_q[i] <= body_q[i-1];
            body_q[0]  <= nextHead_q;
            if (eat_q && (len_q < MAX_LEN_V)) len_q <= len_q + 5'd1;
            stepDone_q <= 1'b1;
            ate_q      <= eat_q;
            state_q    <= ST_WAIT;
          end
          default: begin
            state_q    <= ST_STOP;
            running_q  <= 1'b0;
            gameOver_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign head_x    = body_q[0][7:4];
  assign head_y    = body_q[0][3:0];
  assign length    = len_q;
  assign rd_valid  = ({1'b0, rd_idx} < len_q);
  assign rd_pos    = rd_valid ? body_q[rd_idx] : 8'h00;
  assign step_done = stepDone_q;
  assign ate       = ate_q;
  assign running   = running_q;
  assign game_over = gameOver_q;

endmodule
